// File: rtl/weight_loader.sv
// Packs BEATS_PER_LINE DRAM beats into one weight line and writes each line into the weight buffer.
// A command loads num_lines consecutive lines starting at base; line addresses wrap modulo 2^ADDR_WIDTH.
module weight_loader #(
  parameter int unsigned BEAT_WIDTH     = 256,
  parameter int unsigned BEATS_PER_LINE = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned LINE_WIDTH     = BEAT_WIDTH * BEATS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_cmd_valid,
  output logic                  out_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] in_cmd_base_addr,
  input  logic [ADDR_WIDTH:0]   in_cmd_num_lines,
  input  logic                  in_beat_valid,
  output logic                  out_beat_ready,
  input  logic [BEAT_WIDTH-1:0] in_beat_data,
  output logic                  out_wb_req,
  output logic                  out_wb_we,
  output logic [ADDR_WIDTH-1:0] out_wb_addr,
  output logic [LINE_WIDTH-1:0] out_wb_wdata,
  output logic                  out_busy,
  output logic                  out_done
);

  localparam int unsigned CNT_WIDTH = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH:0]  ONE_LINE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   num_lines_q, num_lines_d;
  logic [ADDR_WIDTH:0]   line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  beat_fire;

  assign beat_fire = in_beat_valid && (state_q == StFill);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_lines_d = num_lines_q;
    line_cnt_d  = line_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (in_cmd_valid) begin
          base_d      = in_cmd_base_addr;
          num_lines_d = in_cmd_num_lines;
          beat_cnt_d  = '0;
          line_cnt_d  = '0;
          state_d     = (in_cmd_num_lines == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        if (in_beat_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = StWrite;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StWrite: begin
        // line_cnt is one bit wider than the address so a 2^ADDR_WIDTH-line load terminates.
        if (line_cnt_q + ONE_LINE == num_lines_q) begin
          state_d = StDone;
        end else begin
          line_cnt_d = line_cnt_q + ONE_LINE;
          state_d    = StFill;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      num_lines_q <= '0;
      line_cnt_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_lines_q <= num_lines_d;
      line_cnt_q  <= line_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Line register is never cleared between lines; it holds the last line after a command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
    end else if (beat_fire) begin
      wdata_q[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= in_beat_data;
    end
  end

  assign out_cmd_ready  = (state_q == StIdle);
  assign out_beat_ready = (state_q == StFill);
  assign out_wb_req     = (state_q == StWrite);
  assign out_wb_we      = (state_q == StWrite);
  assign out_wb_addr    = base_q + line_cnt_q[ADDR_WIDTH-1:0];
  assign out_wb_wdata   = wdata_q;
  assign out_busy       = (state_q != StIdle);
  assign out_done       = (state_q == StDone);

endmodule

// File: doc/weight_loader.md
# weight_loader

Write-side front end for the weight buffer. Accepts a load command (base line address, line count), collects a stream of 256-bit DRAM beats, packs each group of 16 beats into one 4096-bit weight line, and issues one single-cycle write per line on the weight buffer's DRAM port (req/we/addr/wdata). It sits between the DRAM read stream and the weight buffer, and is the only writer of that buffer.

## Interface
- BEAT_WIDTH, 256, width of one DRAM beat
- BEATS_PER_LINE, 16, beats packed per line; LINE_WIDTH = BEAT_WIDTH*BEATS_PER_LINE = 4096
- ADDR_WIDTH, 8, weight-buffer line address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_cmd_valid  in  1  load command valid
- out_cmd_ready  out  1  command accepted when valid & ready
- in_cmd_base_addr  in  ADDR_WIDTH  first line address
- in_cmd_num_lines  in  ADDR_WIDTH+1  lines to load, 0..256
- in_beat_valid  in  1  DRAM beat valid
- out_beat_ready  out  1  beat accepted when valid & ready
- in_beat_data  in  BEAT_WIDTH  beat payload
- out_wb_req  out  1  weight-buffer write request, one cycle per line
- out_wb_we  out  1  write enable, always equal to out_wb_req
- out_wb_addr  out  ADDR_WIDTH  line address of the write
- out_wb_wdata  out  LINE_WIDTH  assembled line
- out_busy  out  1  high whenever state != IDLE
- out_done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: out_cmd_ready=1; on cmd handshake latch base, num_lines; clear beat_cnt, line_cnt. num_lines==0 -> DONE, else -> FILL.
- FILL: out_beat_ready=1. Each accepted beat k (beat_cnt) is written into out_wb_wdata[k*BEAT_WIDTH +: BEAT_WIDTH]; beat 0 lands in bits [255:0]. beat_cnt increments, wraps 15 -> 0. On acceptance of beat 15 -> WRITE.
- WRITE: out_wb_req=out_wb_we=1 for exactly this cycle; out_wb_addr = (base + line_cnt) mod 2^ADDR_WIDTH. out_beat_ready=0. line_cnt+1 == num_lines -> DONE, else line_cnt++ and -> FILL.
- DONE: out_done=1 for one cycle, -> IDLE.
- out_beat_ready=0 in IDLE, WRITE, DONE; out_cmd_ready=0 outside IDLE. in_cmd_valid outside IDLE is ignored (not queued).
- out_wb_wdata is not cleared between lines; it holds the last assembled line after completion.
- Address wrap: base 0xFE, 3 lines -> 0xFE, 0xFF, 0x00. num_lines=256 writes every line once.
- Reset mid-operation: all state to IDLE, partial line discarded, no write issued, no done pulse.
- System note: weight buffer gives writes priority over dispatcher reads on its shared SRAM address; dispatcher reads issued in a WRITE cycle are pre-empted. Software does not read lines being loaded.

## Timing
- Reset values: out_cmd_ready=1 (state IDLE), out_beat_ready=0, out_wb_req=0, out_wb_we=0, out_wb_addr=0, out_wb_wdata=0, out_busy=0, out_done=0.
- All outputs registered or decoded directly from the state register; no input-to-output combinational path.
- Cmd handshake at edge 0 -> FILL from edge 0; out_beat_ready high in cycle after edge 0.
- With in_beat_valid held high: beats accepted at edges 1..16; out_wb_req high between edges 16 and 17 with addr/wdata stable for that cycle; next line's beats from edge 18.
- Per line 17 cycles minimum; N-line command: done high between edges 17N and 17N+1, out_cmd_ready high again from edge 17N+1.
- num_lines==0: done high cycle after handshake edge, no out_wb_req.
- in_beat_valid gaps stall beat_cnt only; no timeout.

## Test plan
- Single line, base 0x10, beat k data = {8{32'(k)}} -> exactly one out_wb_req cycle, addr 0x10, wdata slice k = beat k for k=0..15, done one cycle later, no further req.
- Three lines, base 0xFE, continuous beats -> req at addrs 0xFE, 0xFF, 0x00, spaced 17 cycles; done after third; busy high throughout.
- Random in_beat_valid gaps (about 50%) on 2 lines -> identical wdata/addr to gap-free run; req only after each 16th accepted beat; out_beat_ready low during WRITE/DONE.
- num_lines=0 -> done pulse next cycle, zero req, out_cmd_ready back high after 2 cycles.
- rst_n asserted after 7 beats of line 0 -> outputs return to reset values immediately; no req; new command afterwards loads correctly from beat 0.
- in_cmd_valid pulsed while busy with different base -> ignored; original command completes with original addresses.
